// File: rtl/clock_divider.sv
// Runtime-programmable 50% duty clock divider with tick strobe, run enable
// and single-step support; divisor changes land only on phase boundaries.
module clock_divider #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 51
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             step_busy,
  output logic [DIV_W-1:0] div_cur
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             step_busy_q, step_busy_d;
  logic             step_req_q, step_req_d;

  logic [DIV_W-1:0] load_val;
  logic [DIV_W-1:0] pend_eff;
  logic             last;
  logic             step_rise;

  always_comb begin
    load_val  = (div_i == '0) ? DIV_W'(1) : div_i;
    // A load coinciding with a boundary bypasses the pending register.
    pend_eff  = div_load ? load_val : div_pend_q;
    last      = (cnt_q == div_cur_q - DIV_W'(1));
    step_rise = step_req & ~step_req_q;

    state_d     = state_q;
    cnt_d       = cnt_q + DIV_W'(1);
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    step_busy_d = step_busy_q;
    div_cur_d   = div_cur_q;
    div_pend_d  = pend_eff;
    step_req_d  = step_req;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        div_cur_d = pend_eff;
        if (en && !step_mode) begin
          state_d = LOW;
        end else if (en && step_mode && step_rise) begin
          state_d     = HIGH;
          clk_out_d   = 1'b1;
          tick_d      = 1'b1;
          step_busy_d = 1'b1;
        end
      end
      LOW: begin
        if (last) begin
          cnt_d = '0;
          if (en && !step_mode) begin
            state_d   = HIGH;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HIGH: begin
        if (last) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          div_cur_d = pend_eff;
          if (step_busy_q) begin
            state_d     = IDLE;
            step_busy_d = 1'b0;
          end else begin
            state_d = LOW;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      step_busy_q <= 1'b0;
      div_cur_q   <= DIV_W'(DEFAULT_DIV);
      div_pend_q  <= DIV_W'(DEFAULT_DIV);
      step_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      step_busy_q <= step_busy_d;
      div_cur_q   <= div_cur_d;
      div_pend_q  <= div_pend_d;
      step_req_q  <= step_req_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign step_busy = step_busy_q;
  assign div_cur   = div_cur_q;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: directed scenarios plus random control traffic,
// all checked each cycle against a phase-end-time reference model.
module tb_clock_divider;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         step_mode = 1'b0;
  logic         step_req = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         clk_out, tick, step_busy;
  logic [W-1:0] div_cur;

  clock_divider #(.DIV_W(W), .DEFAULT_DIV(51)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step_mode(step_mode),
    .step_req(step_req), .div_i(div_i), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .step_busy(step_busy), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: phases are described by kind and the edge index they end on.
  int m_phase;  // 0 idle, 1 low, 2 high
  int m_end, m_n, m_pend, cyc;
  bit m_busy, m_prev, m_clk, m_tick;

  task automatic model_reset();
    m_phase = 0; m_n = 51; m_pend = 51; m_busy = 0; m_prev = 0;
    m_clk = 0; m_tick = 0; m_end = 0;
  endtask

  task automatic model_step();
    int ld;
    bit rise;
    cyc++;
    ld     = div_load ? ((div_i == 0) ? 1 : int'(div_i)) : m_pend;
    rise   = step_req && !m_prev;
    m_tick = 0;
    if (m_phase == 0) begin
      m_n = ld;
      if (en && !step_mode) begin
        m_phase = 1; m_end = cyc + m_n;
      end else if (en && step_mode && rise) begin
        m_phase = 2; m_end = cyc + m_n; m_clk = 1; m_tick = 1; m_busy = 1;
      end
    end else if (cyc == m_end) begin
      if (m_phase == 2) begin
        m_clk = 0;
        m_n   = ld;
        if (m_busy) begin
          m_phase = 0; m_busy = 0;
        end else begin
          m_phase = 1; m_end = cyc + m_n;
        end
      end else if (en && !step_mode) begin
        m_phase = 2; m_end = cyc + m_n; m_clk = 1; m_tick = 1;
      end else begin
        m_phase = 0;
      end
    end
    m_pend = ld;
    m_prev = step_req;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check("clk_out", 32'(clk_out), 32'(m_clk));
    check("tick", 32'(tick), 32'(m_tick));
    check("step_busy", 32'(step_busy), 32'(m_busy));
    check("div_cur", 32'(div_cur), 32'(m_n));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic load_div(input int v);
    div_i = W'(v); div_load = 1'b1;
    step_cycle();
    div_load = 1'b0;
  endtask

  task automatic wait_clk(input logic want, output int n);
    n = 0;
    while (clk_out !== want && n < 2000) begin
      step_cycle();
      n++;
    end
    if (n >= 2000) check("wait_timeout", 32'(clk_out), 32'(want));
  endtask

  task automatic wait_rise(output int n);
    int a, b;
    wait_clk(1'b0, a);
    wait_clk(1'b1, b);
    n = a + b;
  endtask

  // Called on a rise cycle; returns high-cycle count and full period.
  task automatic measure_period(output int hi, output int per);
    hi = 0; per = 0;
    do begin
      hi += int'(clk_out);
      step_cycle();
      per++;
    end while (!tick && per < 2000);
  endtask

  initial begin
    int n, hi, per, edge_no, busy_sum, tick_sum;
    cyc = 0;
    model_reset();
    en = 1'b1;
    #12;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(step_busy), 32'd0);
    check("rst_div_cur", 32'(div_cur), 32'd51);

    // Release just after an edge; that edge is counted as edge 1.
    @(posedge clk); #1 rst_n = 1'b1;
    edge_no = 1;
    @(negedge clk);
    while (clk_out !== 1'b1 && edge_no < 300) begin
      step_cycle();
      edge_no++;
    end
    check("first_rise_edge", 32'(edge_no), 32'd53);
    measure_period(hi, per);
    check("default_high", 32'(hi), 32'd51);
    check("default_period", 32'(per), 32'd102);

    // Divisor change at HIGH count 10
    run(10);
    load_div(4);
    check("div_hold_mid_high", 32'(div_cur), 32'd51);
    wait_clk(1'b0, n);
    check("high_not_truncated", 32'(n), 32'd40);
    check("div_after_boundary", 32'(div_cur), 32'd4);
    wait_clk(1'b1, n);
    check("low_len_n4", 32'(n), 32'd4);
    measure_period(hi, per);
    check("high_n4", 32'(hi), 32'd4);
    check("period_n4", 32'(per), 32'd8);

    // Zero clamps to one
    load_div(0);
    wait_rise(n);
    wait_rise(n);
    check("div_clamped", 32'(div_cur), 32'd1);
    measure_period(hi, per);
    check("high_n1", 32'(hi), 32'd1);
    check("period_n1", 32'(per), 32'd2);

    // Enable drop at HIGH count 2, N=4
    load_div(4);
    wait_rise(n);
    wait_rise(n);
    run(2);
    en = 1'b0;
    wait_clk(1'b0, n);
    check("high_completes", 32'(n), 32'd2);
    run(8);
    check("stopped_low", 32'(clk_out), 32'd0);
    en = 1'b1;
    wait_clk(1'b1, n);
    check("restart_latency", 32'(n), 32'd5);

    // Single step, N=3, second request during busy ignored
    step_mode = 1'b1;
    run(20);
    load_div(3);
    run(2);
    check("step_div", 32'(div_cur), 32'd3);
    busy_sum = 0; tick_sum = 0;
    step_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      busy_sum += int'(step_busy);
      tick_sum += int'(tick);
      if (i == 1 || i == 3) step_req = 1'b0;
      if (i == 2) step_req = 1'b1;
    end
    check("step_busy_cycles", 32'(busy_sum), 32'd3);
    check("step_ticks", 32'(tick_sum), 32'd1);

    // Async reset in the middle of a stepped HIGH phase
    run(2);
    step_req = 1'b1;
    step_cycle();
    step_req = 1'b0;
    step_cycle();
    check("pre_rst_high", 32'(clk_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_busy", 32'(step_busy), 32'd0);
    check("async_div_cur", 32'(div_cur), 32'd51);
    model_reset();
    @(negedge clk);
    en = 1'b1; step_mode = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Random control traffic
    load_div(2);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      div_load = ($urandom_range(0, 15) == 0);
      div_i    = W'($urandom_range(0, 5));
      step_cycle();
    end
    div_load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Parametrised, runtime-programmable clock divider for the CPU clock domain; successor to the fixed divide-by-102 CPU clock generator.
- Produces a 50% duty divided clock `clk_out` and a one-cycle `tick` strobe aligned to each rising edge of `clk_out`.
- Adds glitch-free divisor reprogramming, run enable, and a single-step mode for debug stepping of the CPU.
- Sits between the board clock and the CPU core / IO debug controller.

Parameters:
- DIV_W, 16, width of the divisor and the half-period counter.
- DEFAULT_DIV, 51, half-period length in clk cycles after reset. 51 gives the legacy 102-cycle CPU clock period.

Ports:
- clk  input  1  board clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; gates both free-run and step.
- step_mode  input  1  1 = single-step mode, 0 = free-run.
- step_req  input  1  step request level; a 0->1 edge (detected internally on clk) requests one clk_out period.
- div_i  input  DIV_W  new half-period value.
- div_load  input  1  one-cycle strobe that captures div_i.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-clk-cycle strobe, high in the same cycle that clk_out goes 0->1.
- step_busy  output  1  high while a requested step period is in progress.
- div_cur  output  DIV_W  half-period value currently in effect.

Behaviour:
- Reset, async on rst_n=0:
  - State = IDLE, counter = 0, clk_out = 0, tick = 0, step_busy = 0.
  - div_cur = DEFAULT_DIV; pending divisor = DEFAULT_DIV; step edge detector cleared.
  - Reset asserted mid-period aborts the period immediately.
- Divisor rules:
  - N = div_cur. A captured div_i of 0 is clamped to 1.
  - N=1 gives clk_out = clk/2. Each half-period lasts exactly N clk cycles.
  - div_load writes the pending register; the last load before a boundary wins.
  - The pending value is copied to div_cur only at a HIGH->LOW transition or while in IDLE. A half-period is therefore never truncated or stretched mid-phase.
  - div_load in the same cycle as a HIGH->LOW boundary bypasses the register and takes effect at that boundary.
- State machine: IDLE, LOW, HIGH. The counter resets to 0 on every state change.
- IDLE:
  - Outputs: clk_out = 0, counter held at 0.
  - If en=1 and step_mode=0, go to LOW.
  - If en=1, step_mode=1 and a step_req rising edge is seen, go to HIGH: clk_out=1, tick=1, step_busy=1.
- LOW:
  - Count 0..N-1.
  - At N-1, if en=1 and step_mode=0, go to HIGH: clk_out=1, tick=1.
  - At N-1 otherwise, go to IDLE.
- HIGH:
  - Count 0..N-1.
  - At N-1, clk_out goes 0 and the divisor updates.
  - If step_busy, go to IDLE and clear step_busy; otherwise go to LOW.
- Clean stopping:
  - en or step_mode changes take effect only at phase ends, so clk_out never produces a high pulse shorter than N cycles.
  - Dropping en during HIGH completes the HIGH phase, then one LOW phase, then IDLE.
- Step requests:
  - step_req edges while step_busy=1 or step_mode=0 are ignored (not queued).
  - A step produces exactly one HIGH phase of N cycles followed by IDLE (low).
- Latency:
  - With en=1, step_mode=0 at reset release, the first clk_out rise occurs on the (N+2)th clk edge after release: 1 cycle IDLE->LOW, N cycles LOW, then the rise.
  - Steady-state period is 2N.
- Tick: high exactly one cycle per clk_out rise; never high in IDLE or LOW.

Test Plan:
- Default run: reset, en=1, step_mode=0 -> first rise at edge 53 after release. Then period = 102 cycles, high = 51, one tick per rise.
- Divisor change mid-HIGH: div_load with div_i=4 at HIGH count 10 -> current high phase stays 51 cycles; following phases are 4 cycles; div_cur=4 from that boundary.
- Clamp and minimum: load div_i=0 -> div_cur=1; clk_out toggles every cycle; tick every 2 cycles.
- Enable drop: en 1->0 at HIGH count 2 with N=4 -> HIGH finishes (4 cycles), LOW 4 cycles, then IDLE with clk_out=0. en=1 again -> rise after 1+4 cycles.
- Single step: step_mode=1 from IDLE, N=3, step_req pulse -> next cycle clk_out=1, tick=1, step_busy=1 for 3 cycles, then IDLE. A second step_req during busy -> no extra period.
- Async reset mid-HIGH: rst_n=0 -> clk_out=0, step_busy=0, div_cur=51 immediately, without waiting for a clk edge.
